// File: rtl/pixel_writer.sv
// Host write port into the 64x48x4bpp framebuffer: coalesces pixel writes into
// nibble-masked word writes, runs whole-screen fills and yields to the display.
module pixel_writer #(
  parameter int unsigned H_PIX      = 64,
  parameter int unsigned V_PIX      = 48,
  parameter int unsigned IDLE_FLUSH = 15
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [5:0]  px_x,
  input  logic [5:0]  px_y,
  input  logic [3:0]  px_color,
  input  logic        flush_req,
  input  logic        fill_req,
  input  logic [3:0]  fill_color,
  output logic        fill_busy,
  input  logic        mem_busy,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [7:0]  wr_mask,
  output logic        pending
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_FILL  = 2'd3;

  localparam int unsigned WORDS     = V_PIX * (H_PIX / 8);
  localparam logic [8:0]  FILL_LAST = 9'(WORDS - 1);
  localparam logic [7:0]  IDLE_MAX  = 8'(IDLE_FLUSH);

  logic [1:0]  state_q, state_d;
  logic        run_q;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  idle_q, idle_d;
  logic [8:0]  fcnt_q, fcnt_d;
  logic [3:0]  fcol_q, fcol_d;
  logic        fpend_q, fpend_d;

  // Decoded view of the presented pixel
  logic [8:0]  px_addr;
  logic        in_range;
  logic [4:0]  shamt;
  logic [31:0] px_nib, px_nmask;
  logic [7:0]  px_bit;
  logic        mismatch;
  logic        accept, acc_in;
  logic [31:0] data_m;
  logic [7:0]  mask_m;
  logic [7:0]  idle_inc;

  assign px_addr  = {px_y, px_x[5:3]};
  assign in_range = (32'(px_y) < V_PIX);
  assign shamt    = {px_x[2:0], 2'b00};
  assign px_nib   = 32'(px_color) << shamt;
  assign px_nmask = 32'hF << shamt;
  assign px_bit   = 8'd1 << px_x[2:0];
  assign mismatch = px_valid && in_range && (px_addr != addr_q);
  assign idle_inc = idle_q + 8'd1;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      idle_q  <= '0;
      fcnt_q  <= '0;
      fcol_q  <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      idle_q  <= idle_d;
      fcnt_q  <= fcnt_d;
      fcol_q  <= fcol_d;
      fpend_q <= fpend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    idle_d   = idle_q;
    fcnt_d   = fcnt_q;
    fcol_d   = fcol_q;
    fpend_d  = fpend_q;
    px_ready = 1'b0;

    case (state_q)
      S_IDLE: px_ready = run_q && !fill_req;
      S_ACC:  px_ready = !fill_req && !mismatch;
      default: px_ready = 1'b0;
    endcase

    accept = px_valid && px_ready;
    acc_in = accept && in_range;
    data_m = acc_in ? ((data_q & ~px_nmask) | px_nib) : data_q;
    mask_m = acc_in ? (mask_q | px_bit) : mask_q;

    case (state_q)
      S_IDLE: begin
        if (fill_req) begin
          fcol_d  = fill_color;
          fcnt_d  = '0;
          state_d = S_FILL;
        end else if (acc_in) begin
          addr_d  = px_addr;
          data_d  = px_nib;
          mask_d  = px_bit;
          idle_d  = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (fill_req) begin
          fpend_d = 1'b1;
          fcol_d  = fill_color;
          state_d = S_WRITE;
        end else begin
          data_d = data_m;
          mask_d = mask_m;
          // Dropped out-of-range pixels neither reset nor advance the idle count
          if (acc_in)       idle_d = '0;
          else if (!accept) idle_d = idle_inc;
          if (flush_req || mismatch || (mask_m == 8'hFF) ||
              (!accept && (idle_inc == IDLE_MAX)))
            state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!mem_busy) begin
          addr_d = '0;
          data_d = '0;
          mask_d = '0;
          idle_d = '0;
          if (fpend_q) begin
            fpend_d = 1'b0;
            fcnt_d  = '0;
            state_d = S_FILL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FILL: begin
        if (!mem_busy) begin
          if (fcnt_q == FILL_LAST) begin
            fcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            fcnt_d = fcnt_q + 9'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write port is a pure decode of registered state, gated by the display's claim
  always_comb begin
    wr_en   = ((state_q == S_WRITE) || (state_q == S_FILL)) && !mem_busy;
    wr_addr = '0;
    wr_data = '0;
    wr_mask = '0;
    if (wr_en) begin
      if (state_q == S_FILL) begin
        wr_addr = fcnt_q;
        wr_data = {8{fcol_q}};
        wr_mask = 8'hFF;
      end else begin
        wr_addr = addr_q;
        wr_data = data_q;
        wr_mask = mask_q;
      end
    end
    pending   = (state_q == S_ACC) || (state_q == S_WRITE);
    fill_busy = (state_q == S_FILL);
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: coalescing, idle/explicit flush, stalls,
// mem_busy yielding, full-screen fill and reset abort.
module tb_pixel_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        px_valid = 1'b0, px_ready;
  logic [5:0]  px_x = '0, px_y = '0;
  logic [3:0]  px_color = '0;
  logic        flush_req = 1'b0, fill_req = 1'b0;
  logic [3:0]  fill_color = '0;
  logic        fill_busy, mem_busy = 1'b0, wr_en, pending;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  wr_mask;

  int tests = 0;
  int fails = 0;

  logic [8:0]  q_addr[$];
  logic [31:0] q_data[$];
  logic [7:0]  q_mask[$];

  always #5 clk = ~clk;

  pixel_writer dut (
    .clk_25(clk), .rst_n(rst_n), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .flush_req(flush_req),
    .fill_req(fill_req), .fill_color(fill_color), .fill_busy(fill_busy),
    .mem_busy(mem_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .pending(pending)
  );

  // Record every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_mask.push_back(wr_mask);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    q_addr.delete(); q_data.delete(); q_mask.delete();
  endtask

  // Present a pixel (called just after a posedge); returns just after the accepting edge
  task automatic send_px(input logic [5:0] x, input logic [5:0] y, input logic [3:0] c);
    bit ok = 0;
    px_valid = 1'b1; px_x = x; px_y = y; px_color = c;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (px_ready) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_px x=%0d y=%0d: px_ready never 1 within 60 cycles", x, y);
    end
    step();
    px_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    tests++;
    if ({px_ready, fill_busy, wr_en, wr_addr, wr_data, wr_mask, pending} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b fb=%b en=%b a=%h d=%h m=%h p=%b, want all 0",
               px_ready, fill_busy, wr_en, wr_addr, wr_data, wr_mask, pending);
    end
    rst_n = 1'b1;
    step();
    @(negedge clk);
    tests++;
    if (px_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: got %b want 1", px_ready);
    end
    step();
  endtask

  task automatic test_full_word();
    clear_q();
    for (int i = 0; i < 8; i++) send_px(6'(i), 6'd0, 4'(i + 1));
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== 9'h000 || wr_mask !== 8'hFF || wr_data !== 32'h87654321) begin
      fails++;
      $display("FAIL full_word: got en=%b a=%h m=%h d=%h, want 1 000 ff 87654321",
               wr_en, wr_addr, wr_mask, wr_data);
    end
    repeat (5) step();
    tests++;
    if (q_addr.size() != 1) begin
      fails++; $display("FAIL full_word_count: got %0d writes want 1", q_addr.size());
    end
  endtask

  task automatic test_idle_flush();
    int n = 0;
    clear_q();
    send_px(6'd10, 6'd2, 4'h5);
    @(negedge clk);
    n = 1;
    tests++;
    if (pending !== 1'b1) begin
      fails++; $display("FAIL idle_pending: got %b want 1", pending);
    end
    while (!wr_en && n < 40) begin @(negedge clk); n++; end
    tests++;
    if (n < 15 || n > 17) begin
      fails++; $display("FAIL idle_latency: wr_en after %0d cycles, want 15..17", n);
    end
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== 9'h011 || wr_mask !== 8'h04 || wr_data !== 32'h00000500) begin
      fails++;
      $display("FAIL idle_word: got en=%b a=%h m=%h d=%h, want 1 011 04 00000500",
               wr_en, wr_addr, wr_mask, wr_data);
    end
    step(); step();
    tests++;
    if (pending !== 1'b0 || q_addr.size() != 1) begin
      fails++; $display("FAIL idle_after: pending=%b writes=%0d, want 0 and 1", pending, q_addr.size());
    end
  endtask

  task automatic test_mismatch_flush();
    clear_q();
    send_px(6'd3, 6'd1, 4'hA);
    px_valid = 1'b1; px_x = 6'd40; px_y = 6'd1; px_color = 4'hB;
    @(negedge clk);
    tests++;
    if (px_ready !== 1'b0) begin
      fails++; $display("FAIL mismatch_stall: px_ready=%b want 0", px_ready);
    end
    step();
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== 9'h008 || wr_mask !== 8'h08 || wr_data !== 32'h0000A000) begin
      fails++;
      $display("FAIL mismatch_word: got en=%b a=%h m=%h d=%h, want 1 008 08 0000a000",
               wr_en, wr_addr, wr_mask, wr_data);
    end
    step();
    send_px(6'd40, 6'd1, 4'hB);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== 9'h00D || wr_mask !== 8'h01 || wr_data !== 32'h0000000B) begin
      fails++;
      $display("FAIL flush_word: got en=%b a=%h m=%h d=%h, want 1 00d 01 0000000b",
               wr_en, wr_addr, wr_mask, wr_data);
    end
    repeat (3) step();
    tests++;
    if (q_addr.size() != 2) begin
      fails++; $display("FAIL mismatch_count: got %0d writes want 2", q_addr.size());
    end
  endtask

  task automatic test_mem_busy();
    int bad = 0;
    clear_q();
    mem_busy = 1'b1;
    for (int i = 0; i < 8; i++) send_px(6'(i), 6'd3, 4'h9);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || wr_mask !== '0 || px_ready !== 1'b0)
        bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL busy_hold: %0d cycles with outputs active, want 0", bad);
    end
    mem_busy = 1'b0;
    @(negedge clk);
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== 9'h018 || wr_mask !== 8'hFF || wr_data !== 32'h99999999) begin
      fails++;
      $display("FAIL busy_release: got en=%b a=%h m=%h d=%h, want 1 018 ff 99999999",
               wr_en, wr_addr, wr_mask, wr_data);
    end
    repeat (3) step();
    tests++;
    if (q_addr.size() != 1) begin
      fails++; $display("FAIL busy_count: got %0d writes want 1", q_addr.size());
    end
  endtask

  task automatic test_fill();
    int n = 0;
    int bad = 0;
    bit seen_busy = 0;
    clear_q();
    send_px(6'd5, 6'd4, 4'h7);
    fill_req = 1'b1; fill_color = 4'h3;
    step();
    fill_req = 1'b0; fill_color = 4'h0;
    while (n < 1000) begin
      @(negedge clk);
      if (fill_busy) seen_busy = 1;
      if (seen_busy && !fill_busy) break;
      step();
      mem_busy = ((n % 50) >= 10) && ((n % 50) < 13);
      n++;
    end
    mem_busy = 1'b0;
    tests++;
    if (!seen_busy || fill_busy) begin
      fails++; $display("FAIL fill_done: seen_busy=%b fill_busy=%b after %0d cycles", seen_busy, fill_busy, n);
    end
    tests++;
    if (q_addr.size() != 385) begin
      fails++; $display("FAIL fill_count: got %0d writes want 385", q_addr.size());
    end else begin
      tests++;
      if (q_addr[0] !== 9'h020 || q_mask[0] !== 8'h20 || q_data[0] !== 32'h00700000) begin
        fails++;
        $display("FAIL fill_partial: got a=%h m=%h d=%h want 020 20 00700000", q_addr[0], q_mask[0], q_data[0]);
      end
      for (int i = 0; i < 384; i++)
        if (q_addr[i+1] !== 9'(i) || q_mask[i+1] !== 8'hFF || q_data[i+1] !== 32'h33333333) bad++;
      tests++;
      if (bad != 0 || q_addr[384] !== {6'd47, 3'd7}) begin
        fails++; $display("FAIL fill_words: %0d bad words, last addr %h want 17f", bad, q_addr[384]);
      end
    end
    step();
    @(negedge clk);
    tests++;
    if (px_ready !== 1'b1) begin
      fails++; $display("FAIL fill_ready_after: got %b want 1", px_ready);
    end
    step();
  endtask

  task automatic test_out_of_range();
    clear_q();
    send_px(6'd0, 6'd48, 4'hF);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (20) step();
    @(negedge clk);
    tests++;
    if (pending !== 1'b0 || q_addr.size() != 0) begin
      fails++; $display("FAIL out_of_range: pending=%b writes=%0d, want 0 and 0", pending, q_addr.size());
    end
    step();
  endtask

  task automatic test_reset_mid_fill();
    int n = 0;
    clear_q();
    fill_req = 1'b1; fill_color = 4'h6;
    step();
    fill_req = 1'b0;
    while (q_addr.size() < 100 && n < 300) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({px_ready, fill_busy, wr_en, wr_addr, wr_data, wr_mask, pending} !== '0) begin
      fails++;
      $display("FAIL reset_abort: got rdy=%b fb=%b en=%b a=%h d=%h m=%h p=%b, want all 0",
               px_ready, fill_busy, wr_en, wr_addr, wr_data, wr_mask, pending);
    end
    step();
    rst_n = 1'b1;
    clear_q();
    step();
    @(negedge clk);
    tests++;
    if (px_ready !== 1'b1 || fill_busy !== 1'b0) begin
      fails++; $display("FAIL reset_resume: rdy=%b fb=%b want 1 0", px_ready, fill_busy);
    end
    repeat (30) step();
    tests++;
    if (q_addr.size() != 0) begin
      fails++; $display("FAIL reset_no_writes: got %0d writes want 0", q_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_idle_flush();
    test_mismatch_flush();
    test_mem_busy();
    test_fill();
    test_out_of_range();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
